// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - IEEE 1149.1 TAP controller with IR, IDCODE DR and external bypass cell control
//
// Purpose:
//    Decodes TMS into the 16-state TAP FSM, owns the instruction register and
//    the 32-bit IDCODE data register, drives the shift/clock enables of the
//    external single-bit bypass cell and multiplexes the selected register
//    onto TDO on the falling edge of TCK.
//
// Ports:
//    tck_i       in   JTAG test clock
//    trst_i      in   TAP reset, asynchronous, active-high
//    tms_i       in   test mode select, sampled on posedge tck_i
//    tdi_i       in   serial data in
//    by_ser_i    in   serial output of the external bypass cell
//    tdo_o       out  serial data out (changes on negedge tck_i)
//    tdo_en_o    out  TDO output enable, high only in SHIFT_IR / SHIFT_DR
//    by_shift_o  out  bypass cell shift (1) / capture (0) select
//    by_clock_o  out  bypass cell clock enable
//    ir_o        out  current (updated) instruction
//    state_o     out  current TAP state encoding, for debug

module jtag_tap_ctrl #(
   parameter int                  IR_WIDTH   = 4,
   parameter logic [31:0]         IDCODE_VAL = 32'h0A5B_C3D1,
   parameter logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(1),
   parameter logic [IR_WIDTH-1:0] OP_BYPASS  = '1
) (
   input  logic                tck_i,
   input  logic                trst_i,
   input  logic                tms_i,
   input  logic                tdi_i,
   input  logic                by_ser_i,
   output logic                tdo_o,
   output logic                tdo_en_o,
   output logic                by_shift_o,
   output logic                by_clock_o,
   output logic [IR_WIDTH-1:0] ir_o,
   output logic [3:0]          state_o
);

   // Standard 1149.1 state encodings so state_o matches common debug tooling.
   typedef enum logic [3:0] {
      S_TLR      = 4'hF,
      S_RTI      = 4'hC,
      S_SEL_DR   = 4'h7,
      S_CAP_DR   = 4'h6,
      S_SHIFT_DR = 4'h2,
      S_EXIT1_DR = 4'h1,
      S_PAUSE_DR = 4'h3,
      S_EXIT2_DR = 4'h0,
      S_UPD_DR   = 4'h5,
      S_SEL_IR   = 4'h4,
      S_CAP_IR   = 4'hE,
      S_SHIFT_IR = 4'hA,
      S_EXIT1_IR = 4'h9,
      S_PAUSE_IR = 4'hB,
      S_EXIT2_IR = 4'h8,
      S_UPD_IR   = 4'hD
   } tap_state_t;

   tap_state_t          r_state;
   logic [IR_WIDTH-1:0] r_ir;
   logic [IR_WIDTH-1:0] r_ir_shift;
   logic [31:0]         r_id_shift;
   logic                r_tdo;
   logic                r_tdo_en;

   logic                w_sel_idcode;
   logic                w_sel_bypass;

   // Only the IDCODE opcode selects IDCODE; BYPASS and every unrecognised
   // opcode fall through to the bypass cell.
   assign w_sel_idcode = (r_ir == OP_IDCODE);
   assign w_sel_bypass = (r_ir == OP_BYPASS) | ~w_sel_idcode;

   // TAP FSM plus IR / IDCODE shift registers, all on the rising TCK edge.
   // PAUSE and EXIT states fall into the default arm, so the shift registers
   // hold there.
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         r_state    <= S_TLR;
         r_ir       <= OP_IDCODE;
         r_ir_shift <= '0;
         r_id_shift <= '0;
      end else begin
         case (r_state)
            S_TLR:      r_state <= tms_i ? S_TLR      : S_RTI;
            S_RTI:      r_state <= tms_i ? S_SEL_DR   : S_RTI;
            S_SEL_DR:   r_state <= tms_i ? S_SEL_IR   : S_CAP_DR;
            S_SEL_IR:   r_state <= tms_i ? S_TLR      : S_CAP_IR;
            S_CAP_DR:   r_state <= tms_i ? S_EXIT1_DR : S_SHIFT_DR;
            S_SHIFT_DR: r_state <= tms_i ? S_EXIT1_DR : S_SHIFT_DR;
            S_EXIT1_DR: r_state <= tms_i ? S_UPD_DR   : S_PAUSE_DR;
            S_PAUSE_DR: r_state <= tms_i ? S_EXIT2_DR : S_PAUSE_DR;
            S_EXIT2_DR: r_state <= tms_i ? S_UPD_DR   : S_SHIFT_DR;
            S_UPD_DR:   r_state <= tms_i ? S_SEL_DR   : S_RTI;
            S_CAP_IR:   r_state <= tms_i ? S_EXIT1_IR : S_SHIFT_IR;
            S_SHIFT_IR: r_state <= tms_i ? S_EXIT1_IR : S_SHIFT_IR;
            S_EXIT1_IR: r_state <= tms_i ? S_UPD_IR   : S_PAUSE_IR;
            S_PAUSE_IR: r_state <= tms_i ? S_EXIT2_IR : S_PAUSE_IR;
            S_EXIT2_IR: r_state <= tms_i ? S_UPD_IR   : S_SHIFT_IR;
            S_UPD_IR:   r_state <= tms_i ? S_SEL_DR   : S_RTI;
            default:    r_state <= S_TLR;
         endcase

         case (r_state)
            S_TLR:      r_ir       <= OP_IDCODE;
            // Capture pattern ...01 lets a probe detect the IR length.
            S_CAP_IR:   r_ir_shift <= IR_WIDTH'(1);
            S_SHIFT_IR: r_ir_shift <= {tdi_i, r_ir_shift[IR_WIDTH-1:1]};
            S_UPD_IR:   r_ir       <= r_ir_shift;
            S_CAP_DR: begin
               if (w_sel_idcode) r_id_shift <= IDCODE_VAL;
            end
            S_SHIFT_DR: begin
               if (w_sel_idcode) r_id_shift <= {tdi_i, r_id_shift[31:1]};
            end
            default: ;
         endcase
      end
   end

   // TDO launches on the falling edge so the probe can sample it on the next
   // rising edge. Outside the shift states the driver is released and tdo_o
   // keeps its last value.
   always_ff @(negedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         r_tdo    <= 1'b0;
         r_tdo_en <= 1'b0;
      end else begin
         case (r_state)
            S_SHIFT_IR: begin
               r_tdo    <= r_ir_shift[0];
               r_tdo_en <= 1'b1;
            end
            S_SHIFT_DR: begin
               r_tdo    <= w_sel_idcode ? r_id_shift[0] : by_ser_i;
               r_tdo_en <= 1'b1;
            end
            default: r_tdo_en <= 1'b0;
         endcase
      end
   end

   // Bypass cell: clocked in CAP_DR with shift low (loads 0), then shifts TDI
   // in SHIFT_DR. That one register stage is the single TCK of bypass delay.
   assign by_shift_o = w_sel_bypass & (r_state == S_SHIFT_DR);
   assign by_clock_o = w_sel_bypass & ((r_state == S_CAP_DR) | (r_state == S_SHIFT_DR));

   assign tdo_o    = r_tdo;
   assign tdo_en_o = r_tdo_en;
   assign ir_o     = r_ir;
   assign state_o  = r_state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - directed self-checking bench for jtag_tap_ctrl

module tb_jtag_tap_ctrl;

   localparam logic [31:0] IDCODE = 32'h0A5B_C3D1;

   logic       tck_i    = 1'b0;
   logic       trst_i   = 1'b0;
   logic       tms_i    = 1'b1;
   logic       tdi_i    = 1'b0;
   logic       by_ser_i;
   logic       tdo_o;
   logic       tdo_en_o;
   logic       by_shift_o;
   logic       by_clock_o;
   logic [3:0] ir_o;
   logic [3:0] state_o;

   int total = 0;
   int bad   = 0;

   logic r_cell;

   jtag_tap_ctrl dut (
      .tck_i      (tck_i),
      .trst_i     (trst_i),
      .tms_i      (tms_i),
      .tdi_i      (tdi_i),
      .by_ser_i   (by_ser_i),
      .tdo_o      (tdo_o),
      .tdo_en_o   (tdo_en_o),
      .by_shift_o (by_shift_o),
      .by_clock_o (by_clock_o),
      .ir_o       (ir_o),
      .state_o    (state_o)
   );

   always #5 tck_i = ~tck_i;

   // External bypass cell: capture 0, shift TDI.
   always @(posedge tck_i or posedge trst_i) begin
      if (trst_i)          r_cell <= 1'b0;
      else if (by_clock_o) r_cell <= by_shift_o ? tdi_i : 1'b0;
   end
   assign by_ser_i = r_cell;

   task automatic step(input logic tms, input logic tdi);
      tms_i = tms;
      tdi_i = tdi;
      @(posedge tck_i);
      #1;
   endtask

   task automatic load_ir(input logic [3:0] v);
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < 4; i++) step(i == 3, v[i]);
      step(1, 0);
      step(0, 0);
      total++; if (ir_o !== v) begin bad++; $display("FAIL load_ir got=%h exp=%h", ir_o, v); end
   endtask

   task automatic test_reset;
      #2 trst_i = 1'b1;
      #10;
      total++; if (state_o !== 4'hF) begin bad++; $display("FAIL rst_state got=%h exp=F", state_o); end
      total++; if (ir_o !== 4'h1) begin bad++; $display("FAIL rst_ir got=%h exp=1", ir_o); end
      total++; if (tdo_en_o !== 1'b0) begin bad++; $display("FAIL rst_tdo_en got=%b exp=0", tdo_en_o); end
      total++; if (tdo_o !== 1'b0) begin bad++; $display("FAIL rst_tdo got=%b exp=0", tdo_o); end
      total++; if ({by_clock_o, by_shift_o} !== 2'b00) begin bad++; $display("FAIL rst_by got=%b exp=00", {by_clock_o, by_shift_o}); end
      @(negedge tck_i); #1 trst_i = 1'b0;
      for (int i = 0; i < 5; i++) step(1, 0);
      total++; if (state_o !== 4'hF) begin bad++; $display("FAIL tlr_state got=%h exp=F", state_o); end
      total++; if (ir_o !== 4'h1) begin bad++; $display("FAIL tlr_ir got=%h exp=1", ir_o); end
      total++; if (by_clock_o !== 1'b0) begin bad++; $display("FAIL tlr_by_clock got=%b exp=0", by_clock_o); end
      @(negedge tck_i); #1;
      total++; if (tdo_en_o !== 1'b0) begin bad++; $display("FAIL tlr_tdo_en got=%b exp=0", tdo_en_o); end
      step(0, 0);
      total++; if (state_o !== 4'hC) begin bad++; $display("FAIL rti_state got=%h exp=C", state_o); end
   endtask

   task automatic test_ir_capture;
      logic [3:0] got;
      logic [3:0] en;
      step(1, 0);
      total++; if (state_o !== 4'h7) begin bad++; $display("FAIL sel_dr got=%h exp=7", state_o); end
      step(1, 0);
      total++; if (state_o !== 4'h4) begin bad++; $display("FAIL sel_ir got=%h exp=4", state_o); end
      step(0, 0);
      total++; if (state_o !== 4'hE) begin bad++; $display("FAIL cap_ir got=%h exp=E", state_o); end
      step(0, 0);
      total++; if (state_o !== 4'hA) begin bad++; $display("FAIL shift_ir got=%h exp=A", state_o); end
      for (int i = 0; i < 4; i++) begin
         @(negedge tck_i); #1;
         got[i] = tdo_o;
         en[i]  = tdo_en_o;
         step(i == 3, 1);
      end
      total++; if (got !== 4'b0001) begin bad++; $display("FAIL ir_capture got=%b exp=0001", got); end
      total++; if (en !== 4'b1111) begin bad++; $display("FAIL ir_tdo_en got=%b exp=1111", en); end
      total++; if (state_o !== 4'h9) begin bad++; $display("FAIL exit1_ir got=%h exp=9", state_o); end
      step(1, 0);
      total++; if (state_o !== 4'hD) begin bad++; $display("FAIL upd_ir got=%h exp=D", state_o); end
      step(0, 0);
      total++; if (ir_o !== 4'hF) begin bad++; $display("FAIL ir_update got=%h exp=F", ir_o); end
   endtask

   task automatic test_idcode;
      logic [31:0] got;
      int          en_miss;
      en_miss = 0;
      load_ir(4'h1);
      step(1, 0); step(0, 0);
      total++; if (by_clock_o !== 1'b0) begin bad++; $display("FAIL id_cap_by_clock got=%b exp=0", by_clock_o); end
      step(0, 0);
      total++; if (state_o !== 4'h2) begin bad++; $display("FAIL shift_dr got=%h exp=2", state_o); end
      for (int i = 0; i < 32; i++) begin
         @(negedge tck_i); #1;
         got[i] = tdo_o;
         if (tdo_en_o !== 1'b1) en_miss++;
         step(i == 31, 0);
      end
      total++; if (got !== IDCODE) begin bad++; $display("FAIL idcode got=%h exp=%h", got, IDCODE); end
      total++; if (en_miss != 0) begin bad++; $display("FAIL id_tdo_en low_cycles=%0d exp=0", en_miss); end
      total++; if (state_o !== 4'h1) begin bad++; $display("FAIL exit1_dr got=%h exp=1", state_o); end
      @(negedge tck_i); #1;
      total++; if (tdo_en_o !== 1'b0) begin bad++; $display("FAIL exit1_tdo_en got=%b exp=0", tdo_en_o); end
      step(1, 0);
      total++; if (state_o !== 4'h5) begin bad++; $display("FAIL upd_dr got=%h exp=5", state_o); end
      step(0, 0);
   endtask

   task automatic test_pause;
      logic [15:0] got;
      step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge tck_i); #1;
         got[i] = tdo_o;
         step(i == 7, 0);
      end
      step(0, 0); step(0, 0);
      total++; if (state_o !== 4'h3) begin bad++; $display("FAIL pause_dr got=%h exp=3", state_o); end
      @(negedge tck_i); #1;
      total++; if (tdo_en_o !== 1'b0) begin bad++; $display("FAIL pause_tdo_en got=%b exp=0", tdo_en_o); end
      step(1, 0);
      total++; if (state_o !== 4'h0) begin bad++; $display("FAIL exit2_dr got=%h exp=0", state_o); end
      step(0, 0);
      for (int i = 8; i < 16; i++) begin
         @(negedge tck_i); #1;
         got[i] = tdo_o;
         step(i == 15, 0);
      end
      total++; if (got !== 16'hC3D1) begin bad++; $display("FAIL pause_hold got=%h exp=c3d1", got); end
      step(1, 0); step(0, 0);
   endtask

   task automatic test_bypass;
      logic [3:0] pat;
      logic [3:0] got;
      pat = 4'b1101;
      load_ir(4'hF);
      step(1, 0); step(0, 0);
      total++; if ({state_o, by_clock_o, by_shift_o} !== 6'b0110_10) begin bad++; $display("FAIL by_cap got=%b exp=011010", {state_o, by_clock_o, by_shift_o}); end
      step(0, 0);
      total++; if ({by_clock_o, by_shift_o} !== 2'b11) begin bad++; $display("FAIL by_shift_ctl got=%b exp=11", {by_clock_o, by_shift_o}); end
      for (int i = 0; i < 4; i++) begin
         @(negedge tck_i); #1;
         got[i] = tdo_o;
         step(i == 3, pat[i]);
      end
      total++; if (got !== 4'b1010) begin bad++; $display("FAIL bypass_tdo got=%b exp=1010", got); end
      total++; if (by_clock_o !== 1'b0) begin bad++; $display("FAIL by_exit1_clock got=%b exp=0", by_clock_o); end
      step(1, 0); step(0, 0);
      total++; if (by_clock_o !== 1'b0) begin bad++; $display("FAIL by_rti_clock got=%b exp=0", by_clock_o); end
   endtask

   task automatic test_unknown_op;
      logic [1:0] got;
      load_ir(4'h5);
      step(1, 0); step(0, 0);
      total++; if (by_clock_o !== 1'b1) begin bad++; $display("FAIL unk_cap_clock got=%b exp=1", by_clock_o); end
      step(0, 0);
      total++; if (by_shift_o !== 1'b1) begin bad++; $display("FAIL unk_by_shift got=%b exp=1", by_shift_o); end
      for (int i = 0; i < 2; i++) begin
         @(negedge tck_i); #1;
         got[i] = tdo_o;
         step(i == 1, 1);
      end
      total++; if (got !== 2'b10) begin bad++; $display("FAIL unk_tdo got=%b exp=10", got); end
      step(1, 0); step(0, 0);
   endtask

   task automatic test_trst_mid_shift;
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      step(0, 1);
      @(negedge tck_i); #1;
      total++; if (tdo_en_o !== 1'b1) begin bad++; $display("FAIL pre_trst_en got=%b exp=1", tdo_en_o); end
      #2 trst_i = 1'b1;
      #1;
      total++; if (state_o !== 4'hF) begin bad++; $display("FAIL trst_state got=%h exp=F", state_o); end
      total++; if (ir_o !== 4'h1) begin bad++; $display("FAIL trst_ir got=%h exp=1", ir_o); end
      total++; if (tdo_en_o !== 1'b0) begin bad++; $display("FAIL trst_tdo_en got=%b exp=0", tdo_en_o); end
      @(negedge tck_i); #1 trst_i = 1'b0;
      step(1, 1); step(1, 1); step(0, 1);
      total++; if ({state_o, ir_o} !== 8'hC1) begin bad++; $display("FAIL post_trst got=%h exp=c1", {state_o, ir_o}); end
   endtask

   task automatic test_five_tms;
      step(1, 0); step(1, 0); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
      total++; if (state_o !== 4'hB) begin bad++; $display("FAIL pause_ir got=%h exp=B", state_o); end
      for (int i = 0; i < 5; i++) step(1, 0);
      total++; if (state_o !== 4'hF) begin bad++; $display("FAIL five_tms_ir got=%h exp=F", state_o); end
      step(0, 0); step(1, 0); step(0, 0); step(0, 0);
      for (int i = 0; i < 5; i++) step(1, 0);
      total++; if (state_o !== 4'hF) begin bad++; $display("FAIL five_tms_dr got=%h exp=F", state_o); end
      total++; if (ir_o !== 4'h1) begin bad++; $display("FAIL five_tms_ir_val got=%h exp=1", ir_o); end
   endtask

   initial begin
      test_reset;
      test_ir_capture;
      test_idcode;
      test_pause;
      test_bypass;
      test_unknown_op;
      test_trst_mid_shift;
      test_five_tms;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
